// File: rtl/system_decode_stage_if.sv
// Shared decode types and the upstream/downstream bus of system_decode_stage.
// slave is the stage side, master is the dispatch/execute side.
package system_decode_stage_pkg;
  typedef enum logic [2:0] {
    SCALL      = 3'd0,
    SBREAK     = 3'd1,
    RDCYCLE    = 3'd2,
    RDCYCLEH   = 3'd3,
    RDTIME     = 3'd4,
    RDTIMEH    = 3'd5,
    RDINSTRET  = 3'd6,
    RDINSTRETH = 3'd7
  } t_sysop;

  localparam int unsigned CAUSE_W = 2;
  localparam logic [CAUSE_W-1:0] CAUSE_NONE    = 2'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_SCALL   = 2'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_SBREAK  = 2'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL = 2'd3;
endpackage

interface system_decode_stage_if #(
  parameter int unsigned PC_SIZE = 32
);
  import system_decode_stage_pkg::*;

  logic               i_valid;
  logic               o_ready;
  logic [31:0]        i_instr;
  logic [PC_SIZE-1:0] i_pc;
  logic               o_valid;
  logic               i_ready;
  t_sysop             o_op;
  logic [4:0]         o_rd;
  logic [PC_SIZE-1:0] o_pc;
  logic               o_trap;
  logic [1:0]         o_trap_cause;

  modport slave (
    input  i_valid, i_instr, i_pc, i_ready,
    output o_ready, o_valid, o_op, o_rd, o_pc, o_trap, o_trap_cause
  );

  modport master (
    output i_valid, i_instr, i_pc, i_ready,
    input  o_ready, o_valid, o_op, o_rd, o_pc, o_trap, o_trap_cause
  );
endinterface

// File: rtl/system_decode_stage.sv
// SYSTEM-class decode/issue stage: decode, 2-entry skid buffer, trap hold-off FSM.
// Optional macro SYSDEC_ILLEGAL_TRAP_EN: illegal encodings trap (cause 3) instead of being dropped.
module system_decode_stage
  import system_decode_stage_pkg::*;
#(
  parameter int unsigned PC_SIZE = 32
) (
  input  logic                  i_aclk,
  input  logic                  i_areset_n,
  input  logic                  i_flush,
  input  logic                  i_trap_ack,
  system_decode_stage_if.slave  bus
);
  localparam int unsigned RD_W = 5;
  localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;

`ifdef SYSDEC_ILLEGAL_TRAP_EN
  localparam bit ILLEGAL_TRAP = 1'b1;
`else
  localparam bit ILLEGAL_TRAP = 1'b0;
`endif

  typedef enum logic [1:0] {RUN, TRAP_OUT, TRAP_WAIT} t_state;

  t_state state_q, state_d;

  logic               out_valid_q, out_valid_d;
  t_sysop             out_op_q, out_op_d;
  logic [RD_W-1:0]    out_rd_q, out_rd_d;
  logic [PC_SIZE-1:0] out_pc_q, out_pc_d;
  logic [CAUSE_W-1:0] out_cause_q, out_cause_d;
  logic               out_trap_q, out_trap_d;

  logic               skid_valid_q, skid_valid_d;
  t_sysop             skid_op_q, skid_op_d;
  logic [RD_W-1:0]    skid_rd_q, skid_rd_d;
  logic [PC_SIZE-1:0] skid_pc_q, skid_pc_d;
  logic [CAUSE_W-1:0] skid_cause_q, skid_cause_d;

  logic               ready_q, ready_d;

  t_sysop             dec_op;
  logic [RD_W-1:0]    dec_rd;
  logic [CAUSE_W-1:0] dec_cause;
  logic               accept, xfer, keep;

  // Instruction decode; anything unmatched stays illegal
  always_comb begin
    dec_op    = SCALL;
    dec_rd    = '0;
    dec_cause = CAUSE_ILLEGAL;
    if (bus.i_instr[6:0] == OPC_SYSTEM) begin
      if (bus.i_instr[14:12] == 3'b010 && bus.i_instr[19:15] == 5'd0) begin
        dec_rd    = bus.i_instr[11:7];
        dec_cause = CAUSE_NONE;
        case (bus.i_instr[31:20])
          12'hC00: dec_op = RDCYCLE;
          12'hC80: dec_op = RDCYCLEH;
          12'hC01: dec_op = RDTIME;
          12'hC81: dec_op = RDTIMEH;
          12'hC02: dec_op = RDINSTRET;
          12'hC82: dec_op = RDINSTRETH;
          default: begin
            dec_rd    = '0;
            dec_cause = CAUSE_ILLEGAL;
          end
        endcase
      end else if (bus.i_instr[14:12] == 3'b000 && bus.i_instr[11:7] == 5'd0 &&
                   bus.i_instr[19:15] == 5'd0) begin
        if (bus.i_instr[31:20] == 12'h000) begin
          dec_op    = SCALL;
          dec_cause = CAUSE_SCALL;
        end else if (bus.i_instr[31:20] == 12'h001) begin
          dec_op    = SBREAK;
          dec_cause = CAUSE_SBREAK;
        end
      end
    end
  end

  assign accept = bus.i_valid && ready_q;
  assign xfer   = out_valid_q && bus.i_ready;
  assign keep   = accept && (ILLEGAL_TRAP || dec_cause != CAUSE_ILLEGAL);

  // Trap hold-off FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:       if (keep && dec_cause != CAUSE_NONE) state_d = TRAP_OUT;
      TRAP_OUT:  if (xfer && out_trap_q) state_d = TRAP_WAIT;
      TRAP_WAIT: if (i_trap_ack) state_d = RUN;
      default:   state_d = RUN;
    endcase
    if (i_flush) state_d = RUN;
  end

  always_ff @(posedge i_aclk) begin
    if (!i_areset_n) state_q <= RUN;
    else             state_q <= state_d;
  end

  // Output/skid register next values; output is refilled when empty or draining
  always_comb begin
    out_valid_d  = out_valid_q;
    out_op_d     = out_op_q;
    out_rd_d     = out_rd_q;
    out_pc_d     = out_pc_q;
    out_cause_d  = out_cause_q;
    skid_valid_d = skid_valid_q;
    skid_op_d    = skid_op_q;
    skid_rd_d    = skid_rd_q;
    skid_pc_d    = skid_pc_q;
    skid_cause_d = skid_cause_q;
    if (!out_valid_q || xfer) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_op_d     = skid_op_q;
        out_rd_d     = skid_rd_q;
        out_pc_d     = skid_pc_q;
        out_cause_d  = skid_cause_q;
        skid_valid_d = 1'b0;
      end else if (keep) begin
        out_valid_d  = 1'b1;
        out_op_d     = dec_op;
        out_rd_d     = dec_rd;
        out_pc_d     = bus.i_pc;
        out_cause_d  = dec_cause;
      end else begin
        out_valid_d  = 1'b0;
      end
    end else if (keep) begin
      skid_valid_d = 1'b1;
      skid_op_d    = dec_op;
      skid_rd_d    = dec_rd;
      skid_pc_d    = bus.i_pc;
      skid_cause_d = dec_cause;
    end
    if (i_flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end
    out_trap_d = (out_cause_d != CAUSE_NONE);
    ready_d    = (state_d == RUN) && !skid_valid_d;
  end

  always_ff @(posedge i_aclk) begin
    if (!i_areset_n) begin
      out_valid_q  <= 1'b0;
      out_op_q     <= SCALL;
      out_rd_q     <= '0;
      out_pc_q     <= '0;
      out_cause_q  <= CAUSE_NONE;
      out_trap_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_op_q    <= SCALL;
      skid_rd_q    <= '0;
      skid_pc_q    <= '0;
      skid_cause_q <= CAUSE_NONE;
      ready_q      <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_op_q     <= out_op_d;
      out_rd_q     <= out_rd_d;
      out_pc_q     <= out_pc_d;
      out_cause_q  <= out_cause_d;
      out_trap_q   <= out_trap_d;
      skid_valid_q <= skid_valid_d;
      skid_op_q    <= skid_op_d;
      skid_rd_q    <= skid_rd_d;
      skid_pc_q    <= skid_pc_d;
      skid_cause_q <= skid_cause_d;
      ready_q      <= ready_d;
    end
  end

  assign bus.o_ready      = ready_q;
  assign bus.o_valid      = out_valid_q;
  assign bus.o_op         = out_op_q;
  assign bus.o_rd         = out_rd_q;
  assign bus.o_pc         = out_pc_q;
  assign bus.o_trap       = out_trap_q;
  assign bus.o_trap_cause = out_cause_q;
endmodule

// File: tb/tb_system_decode_stage.sv
// Directed self-checking bench for system_decode_stage (honours SYSDEC_ILLEGAL_TRAP_EN).
module tb_system_decode_stage;
  import system_decode_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic trap_ack;
  int   tests = 0;
  int   fails = 0;

  system_decode_stage_if #(.PC_SIZE(32)) bus ();

  system_decode_stage #(.PC_SIZE(32)) dut (
    .i_aclk     (clk),
    .i_areset_n (rst_n),
    .i_flush    (flush),
    .i_trap_ack (trap_ack),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; sample point is 1 time unit after the rising edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    bus.i_valid = v;
    bus.i_instr = instr;
    bus.i_pc    = pc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; trap_ack = 1'b0;
    bus.i_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
    tests++;
    if ({bus.o_valid, bus.o_ready, bus.o_trap, bus.o_trap_cause} !== 5'b01000) begin
      fails++;
      $display("FAIL reset_ctrl: got v/rdy/trap/cause=%b required 01000",
               {bus.o_valid, bus.o_ready, bus.o_trap, bus.o_trap_cause});
    end
    tests++;
    if (bus.o_op !== SCALL || bus.o_rd !== 5'd0 || bus.o_pc !== 32'h0) begin
      fails++;
      $display("FAIL reset_payload: got op=%0d rd=%0d pc=%0h required 0/0/0",
               bus.o_op, bus.o_rd, bus.o_pc);
    end
  endtask

  task automatic test_rdcycle();
    bus.i_ready = 1'b1;
    drive(1'b1, 32'hC0002573, 32'h100);
    cycle();
    drive(1'b0, 32'h0, 32'h0);
    tests++;
    if (!(bus.o_valid === 1'b1 && bus.o_op === RDCYCLE && bus.o_rd === 5'd10 &&
          bus.o_trap === 1'b0 && bus.o_pc === 32'h100)) begin
      fails++;
      $display("FAIL rdcycle: got v=%b op=%0d rd=%0d trap=%b pc=%0h required 1/2/10/0/100",
               bus.o_valid, bus.o_op, bus.o_rd, bus.o_trap, bus.o_pc);
    end
    cycle();
    tests++;
    if (bus.o_valid !== 1'b0) begin
      fails++;
      $display("FAIL rdcycle_drain: got o_valid=%b required 0", bus.o_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.i_ready = 1'b0;
    drive(1'b1, 32'hC8102673, 32'h200);
    cycle();
    tests++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first: got rdy=%b v=%b required 1/1", bus.o_ready, bus.o_valid);
    end
    drive(1'b1, 32'hC0202773, 32'h204);
    cycle();
    drive(1'b0, 32'h0, 32'h0);
    tests++;
    if (bus.o_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_full: got o_ready=%b required 0", bus.o_ready);
    end
    cycle();
    tests++;
    if (!(bus.o_valid === 1'b1 && bus.o_op === RDTIMEH && bus.o_rd === 5'd12 &&
          bus.o_pc === 32'h200 && bus.o_ready === 1'b0)) begin
      fails++;
      $display("FAIL b2b_hold: got v=%b op=%0d rd=%0d pc=%0h rdy=%b required 1/5/12/200/0",
               bus.o_valid, bus.o_op, bus.o_rd, bus.o_pc, bus.o_ready);
    end
    bus.i_ready = 1'b1;
    cycle();
    tests++;
    if (!(bus.o_valid === 1'b1 && bus.o_op === RDINSTRET && bus.o_rd === 5'd14 &&
          bus.o_pc === 32'h204 && bus.o_ready === 1'b1)) begin
      fails++;
      $display("FAIL b2b_second: got v=%b op=%0d rd=%0d pc=%0h rdy=%b required 1/6/14/204/1",
               bus.o_valid, bus.o_op, bus.o_rd, bus.o_pc, bus.o_ready);
    end
    cycle();
    tests++;
    if (bus.o_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_empty: got o_valid=%b required 0", bus.o_valid);
    end
  endtask

  task automatic test_scall();
    bus.i_ready = 1'b1;
    drive(1'b1, 32'h00000073, 32'h300);
    cycle();
    drive(1'b1, 32'hC0002573, 32'h304);
    tests++;
    if (!(bus.o_valid === 1'b1 && bus.o_op === SCALL && bus.o_trap === 1'b1 &&
          bus.o_trap_cause === 2'd1 && bus.o_rd === 5'd0 && bus.o_ready === 1'b0)) begin
      fails++;
      $display("FAIL scall_out: got v=%b op=%0d trap=%b cause=%0d rd=%0d rdy=%b required 1/0/1/1/0/0",
               bus.o_valid, bus.o_op, bus.o_trap, bus.o_trap_cause, bus.o_rd, bus.o_ready);
    end
    cycle(); cycle();
    tests++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b0) begin
      fails++;
      $display("FAIL scall_wait: got v=%b rdy=%b required 0/0", bus.o_valid, bus.o_ready);
    end
    trap_ack = 1'b1;
    cycle();
    trap_ack = 1'b0;
    tests++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      fails++;
      $display("FAIL scall_ack: got v=%b rdy=%b required 0/1", bus.o_valid, bus.o_ready);
    end
    cycle();
    drive(1'b0, 32'h0, 32'h0);
    tests++;
    if (!(bus.o_valid === 1'b1 && bus.o_op === RDCYCLE && bus.o_pc === 32'h304)) begin
      fails++;
      $display("FAIL scall_resume: got v=%b op=%0d pc=%0h required 1/2/304",
               bus.o_valid, bus.o_op, bus.o_pc);
    end
    cycle();
  endtask

  task automatic test_sbreak_ack_ignored();
    bus.i_ready = 1'b0;
    drive(1'b1, 32'h00100073, 32'h400);
    cycle();
    drive(1'b0, 32'h0, 32'h0);
    tests++;
    if (!(bus.o_valid === 1'b1 && bus.o_op === SBREAK && bus.o_trap_cause === 2'd2)) begin
      fails++;
      $display("FAIL sbreak_out: got v=%b op=%0d cause=%0d required 1/1/2",
               bus.o_valid, bus.o_op, bus.o_trap_cause);
    end
    trap_ack = 1'b1;
    cycle();
    trap_ack = 1'b0;
    bus.i_ready = 1'b1;
    cycle();
    cycle();
    tests++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b0) begin
      fails++;
      $display("FAIL sbreak_early_ack: got v=%b rdy=%b required 0/0", bus.o_valid, bus.o_ready);
    end
    trap_ack = 1'b1;
    cycle();
    trap_ack = 1'b0;
    tests++;
    if (bus.o_ready !== 1'b1) begin
      fails++;
      $display("FAIL sbreak_ack: got o_ready=%b required 1", bus.o_ready);
    end
  endtask

  task automatic test_illegal();
    bus.i_ready = 1'b1;
    drive(1'b1, 32'h0000A073, 32'h500);
    cycle();
    drive(1'b0, 32'h0, 32'h0);
`ifdef SYSDEC_ILLEGAL_TRAP_EN
    tests++;
    if (!(bus.o_valid === 1'b1 && bus.o_trap_cause === 2'd3 && bus.o_trap === 1'b1 &&
          bus.o_op === SCALL && bus.o_rd === 5'd0 && bus.o_ready === 1'b0)) begin
      fails++;
      $display("FAIL illegal_trap: got v=%b cause=%0d trap=%b op=%0d rd=%0d rdy=%b required 1/3/1/0/0/0",
               bus.o_valid, bus.o_trap_cause, bus.o_trap, bus.o_op, bus.o_rd, bus.o_ready);
    end
    cycle();
    trap_ack = 1'b1;
    cycle();
    trap_ack = 1'b0;
    tests++;
    if (bus.o_ready !== 1'b1) begin
      fails++;
      $display("FAIL illegal_ack: got o_ready=%b required 1", bus.o_ready);
    end
`else
    tests++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_trap_cause === 2'd3) begin
      fails++;
      $display("FAIL illegal_drop: got v=%b rdy=%b cause=%0d required 0/1/not3",
               bus.o_valid, bus.o_ready, bus.o_trap_cause);
    end
    cycle();
    tests++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      fails++;
      $display("FAIL illegal_stay: got v=%b rdy=%b required 0/1", bus.o_valid, bus.o_ready);
    end
`endif
  endtask

  task automatic test_flush();
    bus.i_ready = 1'b0;
    drive(1'b1, 32'hC0102673, 32'h600);
    cycle();
    drive(1'b1, 32'hC8202773, 32'h604);
    cycle();
    drive(1'b1, 32'hC0002573, 32'h608);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tests++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_full: got v=%b rdy=%b required 0/1", bus.o_valid, bus.o_ready);
    end
    bus.i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++;
      if (bus.o_valid !== 1'b0) begin
        fails++;
        $display("FAIL flush_ghost: cycle %0d got o_valid=%b pc=%0h required 0",
                 i, bus.o_valid, bus.o_pc);
      end
    end
    drive(1'b1, 32'hC0002573, 32'h700);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tests++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_accept: got v=%b rdy=%b required 0/1", bus.o_valid, bus.o_ready);
    end
  endtask

  task automatic test_reset_mid();
    bus.i_ready = 1'b0;
    drive(1'b1, 32'hC8002573, 32'h800);
    cycle();
    drive(1'b1, 32'h00000073, 32'h804);
    cycle();
    drive(1'b0, 32'h0, 32'h0);
    tests++;
    if (!(bus.o_valid === 1'b1 && bus.o_op === RDCYCLEH && bus.o_ready === 1'b0)) begin
      fails++;
      $display("FAIL midrst_pre: got v=%b op=%0d rdy=%b required 1/3/0",
               bus.o_valid, bus.o_op, bus.o_ready);
    end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    tests++;
    if (!(bus.o_valid === 1'b0 && bus.o_ready === 1'b1 && bus.o_op === SCALL &&
          bus.o_rd === 5'd0 && bus.o_pc === 32'h0 && bus.o_trap_cause === 2'd0)) begin
      fails++;
      $display("FAIL midrst: got v=%b rdy=%b op=%0d rd=%0d pc=%0h cause=%0d required 0/1/0/0/0/0",
               bus.o_valid, bus.o_ready, bus.o_op, bus.o_rd, bus.o_pc, bus.o_trap_cause);
    end
    bus.i_ready = 1'b1;
    cycle();
    tests++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrst_post: got v=%b rdy=%b required 0/1", bus.o_valid, bus.o_ready);
    end
  endtask

  initial begin
    test_reset();
    test_rdcycle();
    test_back_to_back();
    test_scall();
    test_sbreak_ack_ignored();
    test_illegal();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/system_decode_stage.md
Name: system_decode_stage

Overview:
- Decode/issue stage directly upstream of the SYSTEM execute unit.
- Accepts raw 32-bit SYSTEM-class instructions from the dispatch path over a valid/ready handshake.
- Decodes each instruction into a t_sysop, a destination register and a trap cause, then presents them to the execute unit through a 2-entry skid buffer.
- Holds off further issue after SCALL, SBREAK or an illegal encoding until the trap controller acknowledges.

Parameters:
PC_SIZE, 32, width of the program counter carried with each instruction.

Ports:
i_aclk  in  1  stage clock
i_areset_n  in  1  reset, synchronous, active-low
i_flush  in  1  pipeline flush; discards all held entries
i_valid  in  1  upstream instruction valid
o_ready  out  1  stage can accept an instruction this cycle
i_instr  in  32  raw instruction word
i_pc  in  PC_SIZE  PC of i_instr
o_valid  out  1  decoded entry valid toward execute unit
i_ready  in  1  execute unit accepts the entry
o_op  out  t_sysop  decoded system operation
o_rd  out  5  destination register index
o_pc  out  PC_SIZE  PC of the entry
o_trap  out  1  entry raises a trap
o_trap_cause  out  2  0 none, 1 SCALL, 2 SBREAK, 3 illegal
i_trap_ack  in  1  trap controller has taken the trap

Behaviour:
- Single clock i_aclk. i_areset_n is synchronous and active-low, sampled only on the rising edge.
- Reset values: o_valid=0, o_trap=0, o_trap_cause=0, o_op=SCALL, o_rd=0, o_pc=0. FSM=RUN. Skid buffer empty, so o_ready=1 the cycle after reset releases.
- Accept: i_valid && o_ready. Transfer out: o_valid && i_ready.
- Latency: an accepted instruction appears on the outputs on the next cycle when the output register is free or draining.
- Skid buffer: if the output register is held (o_valid && !i_ready) while an instruction is accepted, that instruction goes to the skid register. When the output is taken, the skid entry moves to the output.
- o_ready = (state==RUN) && skid empty, driven from registers only (no combinational path from i_ready).
- Decode, SYSTEM opcode 7'b1110011:
  - funct3=010, rs1=0, CSR 0xC00/0xC80/0xC01/0xC81/0xC02/0xC82 -> RDCYCLE/RDCYCLEH/RDTIME/RDTIMEH/RDINSTRET/RDINSTRETH. o_rd = instr[11:7], cause 0.
  - funct3=000, rd=0, rs1=0: imm 0 -> SCALL, cause 1; imm 1 -> SBREAK, cause 2. o_rd = 0.
  - Any other encoding, including a non-SYSTEM opcode: illegal, cause 3, o_op=SCALL, o_rd=0.
- o_trap = (o_trap_cause != 0).
- FSM states:
  - RUN -> TRAP_OUT when an entry with a nonzero cause is accepted. o_ready is 0 from the next cycle.
  - TRAP_OUT -> TRAP_WAIT when the trap entry transfers out. i_trap_ack is ignored in TRAP_OUT.
  - TRAP_WAIT -> RUN on i_trap_ack. o_ready returns to 1 the following cycle.
  - Entries accepted before the trap entry drain normally. No entry is ever accepted behind a trap entry.
- Flush: i_flush=1 empties both buffer registers and forces RUN. o_valid=0 and o_ready=1 on the next cycle.
- Flush priority: over a simultaneous accept (the input is dropped), a simultaneous transfer (the execute unit still sees the transfer in that cycle) and a simultaneous i_trap_ack.
- Reset mid-operation behaves identically to flush and additionally restores the output reset values.
- Back-pressure: with i_ready held 0, the stage holds at most 2 entries. o_ready falls once the skid register fills. Outputs stay stable while o_valid && !i_ready.

Optional Feature:
- Macro SYSDEC_ILLEGAL_TRAP_EN.
- Defined: illegal encodings get cause 3 and stall the stage via the trap FSM, as above.
- Undefined: illegal encodings are dropped at accept. No output entry is produced, the FSM stays in RUN and o_trap_cause never takes value 3.

Test Plan:
- Reset, then i_instr=0xC0002573 (rdcycle a0), i_valid=1, i_ready=1 -> next cycle o_valid=1, o_op=RDCYCLE, o_rd=10, o_trap=0, o_pc=i_pc.
- Send 0xC8102673 then 0xC0202773 back-to-back with i_ready=0 for 3 cycles -> o_ready=0 after the 2nd accept. Releasing i_ready yields RDTIMEH rd=12, then RDINSTRET rd=14, in order with no loss.
- Send 0x00000073 (ecall) followed by a valid rdcycle -> SCALL out with cause 1. o_ready stays 0 until 1 cycle after i_trap_ack. The rdcycle is issued only after that.
- Send 0x00100073 (ebreak) and assert i_trap_ack while the entry is still held (i_ready=0) -> ack ignored. A second ack after transfer returns the FSM to RUN.
- Send 0x0000A073 (illegal) -> with SYSDEC_ILLEGAL_TRAP_EN, cause 3 and stall. Without it, no o_valid and o_ready remains 1.
- With 2 entries held, assert i_flush together with i_valid -> next cycle o_valid=0, o_ready=1, and the flushed input never appears.
